// File: rtl/control_sequencer_if.sv
// rtl/control_sequencer_if.sv - instruction/handshake inputs and datapath control outputs of the sequencer
interface control_sequencer_if;
    logic [31:0] IR;
    logic        mem_ready;
    logic        con_ff;
    logic        stop;
    logic        Gra, Grb, Grc, Rin, Rout, BAout;
    logic        PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin;
    logic        Yin, Zin, Zlowout, Cout, CONin, Read, Write;
    logic [4:0]  alu_op;
    logic        run;
    logic [3:0]  step;

    modport master (
        output IR, mem_ready, con_ff, stop,
        input  Gra, Grb, Grc, Rin, Rout, BAout,
        input  PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin,
        input  Yin, Zin, Zlowout, Cout, CONin, Read, Write,
        input  alu_op, run, step
    );

    modport slave (
        input  IR, mem_ready, con_ff, stop,
        output Gra, Grb, Grc, Rin, Rout, BAout,
        output PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin,
        output Yin, Zin, Zlowout, Cout, CONin, Read, Write,
        output alu_op, run, step
    );
endinterface

// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - T-state control sequencer decoding fetch, R-type, ld, st, br, nop and halt
module control_sequencer (
    input  logic                clock,
    input  logic                reset,
    control_sequencer_if.slave  bus
);
    typedef enum logic [3:0] {
        T0 = 4'd0, T1 = 4'd1, T2 = 4'd2, T3 = 4'd3,
        T4 = 4'd4, T5 = 4'd5, T6 = 4'd6, T7 = 4'd7,
        HALT = 4'd8
    } state_t;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_BR   = 5'b10010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    state_t     r_state;
    state_t     w_next;
    logic [4:0] w_opcode;
    logic       w_rtype;
    logic       w_mem;
    logic       w_unused_ir;

    assign w_opcode    = bus.IR[31:27];
    assign w_rtype     = (w_opcode == OP_ADD) || (w_opcode == OP_SUB) ||
                         (w_opcode == OP_AND) || (w_opcode == OP_OR);
    assign w_mem       = (w_opcode == OP_LD) || (w_opcode == OP_ST);
    assign w_unused_ir = ^bus.IR[26:0];

    always_ff @(posedge clock) begin
        if (reset) r_state <= T0;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        bus.Gra     = 1'b0; bus.Grb    = 1'b0; bus.Grc   = 1'b0;
        bus.Rin     = 1'b0; bus.Rout   = 1'b0; bus.BAout = 1'b0;
        bus.PCout   = 1'b0; bus.PCin   = 1'b0; bus.IncPC = 1'b0;
        bus.MARin   = 1'b0; bus.MDRin  = 1'b0; bus.MDRout = 1'b0;
        bus.IRin    = 1'b0; bus.Yin    = 1'b0; bus.Zin   = 1'b0;
        bus.Zlowout = 1'b0; bus.Cout   = 1'b0; bus.CONin = 1'b0;
        bus.Read    = 1'b0; bus.Write  = 1'b0;
        bus.alu_op  = OP_ADD;
        bus.run     = 1'b1;
        bus.step    = r_state;

        case (r_state)
            T0: if (!bus.stop) begin
                bus.PCout = 1'b1; bus.MARin = 1'b1; bus.IncPC = 1'b1; bus.Zin = 1'b1;
                w_next = T1;
            end
            T1: begin
                bus.Zlowout = 1'b1; bus.PCin = 1'b1; bus.Read = 1'b1; bus.MDRin = 1'b1;
                if (bus.mem_ready) w_next = T2;
            end
            T2: begin
                bus.MDRout = 1'b1; bus.IRin = 1'b1;
                w_next = T3;
            end
            T3: begin
                w_next = T4;
                if (w_rtype) begin
                    bus.Grb = 1'b1; bus.Rout = 1'b1; bus.Yin = 1'b1;
                end else if (w_mem) begin
                    bus.Grb = 1'b1; bus.BAout = 1'b1; bus.Yin = 1'b1;
                end else if (w_opcode == OP_BR) begin
                    bus.Gra = 1'b1; bus.Rout = 1'b1; bus.CONin = 1'b1;
                end else if (w_opcode == OP_HALT) begin
                    w_next = HALT;
                end else begin
                    w_next = T0;
                end
            end
            T4: begin
                w_next = T5;
                if (w_rtype) begin
                    bus.Grc = 1'b1; bus.Rout = 1'b1; bus.Zin = 1'b1; bus.alu_op = w_opcode;
                end else if (w_mem) begin
                    bus.Cout = 1'b1; bus.Zin = 1'b1;
                end else if (w_opcode == OP_BR) begin
                    bus.PCout = 1'b1; bus.Yin = 1'b1;
                end else begin
                    w_next = T0;
                end
            end
            T5: begin
                w_next = T0;
                if (w_rtype) begin
                    bus.Zlowout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1;
                end else if (w_mem) begin
                    bus.Zlowout = 1'b1; bus.MARin = 1'b1; w_next = T6;
                end else if (w_opcode == OP_BR) begin
                    bus.Cout = 1'b1; bus.Zin = 1'b1; w_next = T6;
                end
            end
            T6: begin
                w_next = T0;
                if (w_opcode == OP_LD) begin
                    bus.Read = 1'b1; bus.MDRin = 1'b1;
                    w_next = bus.mem_ready ? T7 : T6;
                end else if (w_opcode == OP_ST) begin
                    bus.Gra = 1'b1; bus.Rout = 1'b1; bus.MDRin = 1'b1; w_next = T7;
                end else if (w_opcode == OP_BR) begin
                    bus.Zlowout = 1'b1; bus.PCin = bus.con_ff;
                end
            end
            T7: begin
                w_next = T0;
                if (w_opcode == OP_LD) begin
                    bus.MDRout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1;
                end else if (w_opcode == OP_ST) begin
                    bus.Write = 1'b1;
                    w_next = bus.mem_ready ? T0 : T7;
                end
            end
            HALT: bus.run = 1'b0;
            default: w_next = T0;
        endcase

        // Reset forces a quiet bus combinationally, not just from the next edge
        if (reset) begin
            bus.Gra     = 1'b0; bus.Grb    = 1'b0; bus.Grc   = 1'b0;
            bus.Rin     = 1'b0; bus.Rout   = 1'b0; bus.BAout = 1'b0;
            bus.PCout   = 1'b0; bus.PCin   = 1'b0; bus.IncPC = 1'b0;
            bus.MARin   = 1'b0; bus.MDRin  = 1'b0; bus.MDRout = 1'b0;
            bus.IRin    = 1'b0; bus.Yin    = 1'b0; bus.Zin   = 1'b0;
            bus.Zlowout = 1'b0; bus.Cout   = 1'b0; bus.CONin = 1'b0;
            bus.Read    = 1'b0; bus.Write  = 1'b0;
            bus.alu_op  = 5'b00000;
            bus.run     = 1'b0;
            bus.step    = 4'd0;
        end
    end
endmodule

// File: tb/tb_control_sequencer.sv
// tb/tb_control_sequencer.sv - table-driven scoreboard bench for control_sequencer
module tb_control_sequencer;
    logic clock = 1'b0;
    logic reset = 1'b1;
    control_sequencer_if bus ();

    control_sequencer dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    localparam logic [19:0] GRA   = 20'h80000, GRB   = 20'h40000, GRC    = 20'h20000;
    localparam logic [19:0] RIN   = 20'h10000, ROUT  = 20'h08000, BAOUT  = 20'h04000;
    localparam logic [19:0] PCOUT = 20'h02000, PCIN  = 20'h01000, INCPC  = 20'h00800;
    localparam logic [19:0] MARIN = 20'h00400, MDRIN = 20'h00200, MDROUT = 20'h00100;
    localparam logic [19:0] IRIN  = 20'h00080, YIN   = 20'h00040, ZIN    = 20'h00020;
    localparam logic [19:0] ZLOW  = 20'h00010, COUT  = 20'h00008, CONIN  = 20'h00004;
    localparam logic [19:0] READ  = 20'h00002, WRITE = 20'h00001, NONE   = 20'h00000;
    localparam logic [4:0]  ADD   = 5'b00011;

    localparam logic [31:0] IR_ADD  = 32'h1A0B8000;
    localparam logic [31:0] IR_SUB  = {5'b00100, 27'h0123456};
    localparam logic [31:0] IR_AND  = {5'b00101, 27'h0000001};
    localparam logic [31:0] IR_OR   = {5'b00110, 27'h7FFFFFF};
    localparam logic [31:0] IR_LD   = {5'b00000, 27'h0400010};
    localparam logic [31:0] IR_ST   = {5'b00010, 27'h0200020};
    localparam logic [31:0] IR_BR   = {5'b10010, 27'h0800000};
    localparam logic [31:0] IR_NOP  = {5'b11010, 27'h0};
    localparam logic [31:0] IR_UND  = {5'b11111, 27'h0};
    localparam logic [31:0] IR_HALT = {5'b11011, 27'h0};

    typedef struct {
        string       name;
        logic        rst;
        logic [31:0] ir;
        logic        mr, cf, sp;
        logic [3:0]  step;
        logic        run;
        logic [4:0]  alu;
        logic [19:0] strb;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    function automatic void row(string n, logic r, logic [31:0] ir, logic mr, logic cf, logic sp,
                                logic [3:0] st, logic rn, logic [4:0] al, logic [19:0] sb);
        vec_t v;
        v.name = n; v.rst = r; v.ir = ir; v.mr = mr; v.cf = cf; v.sp = sp;
        v.step = st; v.run = rn; v.alu = al; v.strb = sb;
        vecs.push_back(v);
    endfunction

    function automatic void nrm(string n, logic [31:0] ir, logic mr, logic cf, logic sp,
                                logic [3:0] st, logic [19:0] sb);
        row(n, 1'b0, ir, mr, cf, sp, st, 1'b1, ADD, sb);
    endfunction

    function automatic void fetch(string n, logic [31:0] ir, logic cf);
        nrm({n, "_t0"}, ir, 1'b0, cf, 1'b0, 4'd0, PCOUT | MARIN | INCPC | ZIN);
        nrm({n, "_t1"}, ir, 1'b1, cf, 1'b0, 4'd1, ZLOW | PCIN | READ | MDRIN);
        nrm({n, "_t2"}, ir, 1'b0, cf, 1'b0, 4'd2, MDROUT | IRIN);
    endfunction

    function automatic logic [19:0] strobes();
        return {bus.Gra, bus.Grb, bus.Grc, bus.Rin, bus.Rout, bus.BAout,
                bus.PCout, bus.PCin, bus.IncPC, bus.MARin, bus.MDRin, bus.MDRout,
                bus.IRin, bus.Yin, bus.Zin, bus.Zlowout, bus.Cout, bus.CONin,
                bus.Read, bus.Write};
    endfunction

    task automatic apply(input vec_t v);
        vec_t e;
        logic [29:0] act, req;
        int gr;
        reset         = v.rst;
        bus.IR        = v.ir;
        bus.mem_ready = v.mr;
        bus.con_ff    = v.cf;
        bus.stop      = v.sp;
        exp_q.push_back(v);
        @(negedge clock);
        e   = exp_q.pop_front();
        act = {bus.run, bus.step, bus.alu_op, strobes()};
        req = {e.run, e.step, e.alu, e.strb};
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: run/step/alu/strobes got %b/%0d/%b/%h expected %b/%0d/%b/%h",
                     e.name, bus.run, bus.step, bus.alu_op, strobes(),
                     e.run, e.step, e.alu, e.strb);
        end
        gr = int'(bus.Gra) + int'(bus.Grb) + int'(bus.Grc);
        checks++;
        if (gr > 1 || (gr == 1 && !(bus.Rin ^ (bus.Rout | bus.BAout)))) begin
            errors++;
            $display("FAIL %s_gr_excl: gr count %0d Rin %b Rout %b BAout %b required one Gr with one of Rin/Rout",
                     e.name, gr, bus.Rin, bus.Rout, bus.BAout);
        end
        @(posedge clock);
        #1;
    endtask

    initial begin
        bus.IR = 32'h0; bus.mem_ready = 1'b0; bus.con_ff = 1'b0; bus.stop = 1'b0;

        row("reset", 1'b1, IR_ADD, 1'b1, 1'b1, 1'b1, 4'd0, 1'b0, 5'b00000, NONE);

        fetch("add", IR_ADD, 1'b0);
        nrm("add_t3", IR_ADD, 1'b0, 1'b0, 1'b0, 4'd3, GRB | ROUT | YIN);
        row("add_t4", 1'b0, IR_ADD, 1'b0, 1'b0, 1'b0, 4'd4, 1'b1, 5'b00011, GRC | ROUT | ZIN);
        nrm("add_t5", IR_ADD, 1'b0, 1'b0, 1'b0, 4'd5, ZLOW | GRA | RIN);

        nrm("sub_t0_mr_ign", IR_SUB, 1'b1, 1'b0, 1'b0, 4'd0, PCOUT | MARIN | INCPC | ZIN);
        nrm("sub_t1_wait", IR_SUB, 1'b0, 1'b0, 1'b0, 4'd1, ZLOW | PCIN | READ | MDRIN);
        nrm("sub_t1", IR_SUB, 1'b1, 1'b0, 1'b0, 4'd1, ZLOW | PCIN | READ | MDRIN);
        nrm("sub_t2_stop_ign", IR_SUB, 1'b0, 1'b0, 1'b1, 4'd2, MDROUT | IRIN);
        nrm("sub_t3", IR_SUB, 1'b0, 1'b0, 1'b1, 4'd3, GRB | ROUT | YIN);
        row("sub_t4", 1'b0, IR_SUB, 1'b0, 1'b0, 1'b0, 4'd4, 1'b1, 5'b00100, GRC | ROUT | ZIN);
        nrm("sub_t5", IR_SUB, 1'b0, 1'b0, 1'b0, 4'd5, ZLOW | GRA | RIN);

        fetch("and", IR_AND, 1'b0);
        nrm("and_t3", IR_AND, 1'b0, 1'b0, 1'b0, 4'd3, GRB | ROUT | YIN);
        row("and_t4", 1'b0, IR_AND, 1'b0, 1'b0, 1'b0, 4'd4, 1'b1, 5'b00101, GRC | ROUT | ZIN);
        nrm("and_t5", IR_AND, 1'b0, 1'b0, 1'b0, 4'd5, ZLOW | GRA | RIN);
        fetch("or", IR_OR, 1'b0);
        nrm("or_t3", IR_OR, 1'b0, 1'b0, 1'b0, 4'd3, GRB | ROUT | YIN);
        row("or_t4", 1'b0, IR_OR, 1'b0, 1'b0, 1'b0, 4'd4, 1'b1, 5'b00110, GRC | ROUT | ZIN);
        nrm("or_t5", IR_OR, 1'b0, 1'b0, 1'b0, 4'd5, ZLOW | GRA | RIN);

        fetch("nop", IR_NOP, 1'b0);
        nrm("nop_t3", IR_NOP, 1'b0, 1'b0, 1'b0, 4'd3, NONE);
        fetch("undef", IR_UND, 1'b0);
        nrm("undef_t3", IR_UND, 1'b0, 1'b0, 1'b0, 4'd3, NONE);

        for (int c = 0; c < 2; c++) begin
            fetch(c == 0 ? "br0" : "br1", IR_BR, c[0]);
            nrm("br_t3", IR_BR, 1'b0, c[0], 1'b0, 4'd3, GRA | ROUT | CONIN);
            nrm("br_t4", IR_BR, 1'b0, c[0], 1'b0, 4'd4, PCOUT | YIN);
            nrm("br_t5", IR_BR, 1'b0, c[0], 1'b0, 4'd5, COUT | ZIN);
            nrm(c == 0 ? "br_t6_cf0" : "br_t6_cf1", IR_BR, 1'b0, c[0], 1'b0, 4'd6,
                c == 0 ? ZLOW : (ZLOW | PCIN));
        end

        fetch("ld", IR_LD, 1'b0);
        nrm("ld_t3_mr_ign", IR_LD, 1'b1, 1'b0, 1'b0, 4'd3, GRB | BAOUT | YIN);
        nrm("ld_t4", IR_LD, 1'b1, 1'b0, 1'b0, 4'd4, COUT | ZIN);
        nrm("ld_t5", IR_LD, 1'b0, 1'b0, 1'b0, 4'd5, ZLOW | MARIN);
        for (int w = 0; w < 3; w++)
            nrm("ld_t6_wait", IR_LD, 1'b0, 1'b0, 1'b0, 4'd6, READ | MDRIN);
        nrm("ld_t6_done", IR_LD, 1'b1, 1'b0, 1'b0, 4'd6, READ | MDRIN);
        nrm("ld_t7", IR_LD, 1'b0, 1'b0, 1'b0, 4'd7, MDROUT | GRA | RIN);

        for (int s = 0; s < 5; s++)
            nrm("stop_t0", IR_ST, 1'b1, 1'b0, 1'b1, 4'd0, NONE);
        fetch("st", IR_ST, 1'b0);
        nrm("st_t3", IR_ST, 1'b0, 1'b0, 1'b0, 4'd3, GRB | BAOUT | YIN);
        nrm("st_t4", IR_ST, 1'b0, 1'b0, 1'b0, 4'd4, COUT | ZIN);
        nrm("st_t5", IR_ST, 1'b0, 1'b0, 1'b0, 4'd5, ZLOW | MARIN);
        nrm("st_t6", IR_ST, 1'b1, 1'b0, 1'b0, 4'd6, GRA | ROUT | MDRIN);
        nrm("st_t7_wait", IR_ST, 1'b0, 1'b0, 1'b0, 4'd7, WRITE);
        nrm("st_t7_done", IR_ST, 1'b1, 1'b0, 1'b0, 4'd7, WRITE);

        fetch("st_rst", IR_ST, 1'b0);
        nrm("st_rst_t3", IR_ST, 1'b0, 1'b0, 1'b0, 4'd3, GRB | BAOUT | YIN);
        nrm("st_rst_t4", IR_ST, 1'b0, 1'b0, 1'b0, 4'd4, COUT | ZIN);
        nrm("st_rst_t5", IR_ST, 1'b0, 1'b0, 1'b0, 4'd5, ZLOW | MARIN);
        nrm("st_rst_t6", IR_ST, 1'b0, 1'b0, 1'b0, 4'd6, GRA | ROUT | MDRIN);
        nrm("st_rst_t7_wait", IR_ST, 1'b0, 1'b0, 1'b0, 4'd7, WRITE);
        row("st_rst_assert", 1'b1, IR_ST, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 5'b00000, NONE);
        nrm("st_rst_after", IR_ST, 1'b0, 1'b0, 1'b0, 4'd0, PCOUT | MARIN | INCPC | ZIN);
        nrm("st_rst_t1", IR_ST, 1'b1, 1'b0, 1'b0, 4'd1, ZLOW | PCIN | READ | MDRIN);
        nrm("st_rst_t2", IR_ST, 1'b0, 1'b0, 1'b0, 4'd2, MDROUT | IRIN);
        nrm("st_rst_t3b", IR_HALT, 1'b0, 1'b0, 1'b0, 4'd3, NONE);

        for (int h = 0; h < 20; h++)
            row("halt_hold", 1'b0, IR_HALT, h[0], h[1], h[2], 4'd8, 1'b0, ADD, NONE);
        row("halt_reset", 1'b1, IR_HALT, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 5'b00000, NONE);
        nrm("halt_exit_t0", IR_ADD, 1'b0, 1'b0, 1'b0, 4'd0, PCOUT | MARIN | INCPC | ZIN);
        nrm("halt_exit_t1", IR_ADD, 1'b0, 1'b0, 1'b0, 4'd1, ZLOW | PCIN | READ | MDRIN);

        @(posedge clock);
        #1;
        foreach (vecs[i]) apply(vecs[i]);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 The block SHALL have the port: clock  in  1  rising-edge clock.
REQ-002 The block SHALL have the port: reset  in  1  synchronous active-high reset.
REQ-003 The block SHALL have the port: IR  in  32  instruction register; opcode is IR[31:27].
REQ-004 The block SHALL have the port: mem_ready  in  1  memory done; it completes a Read or Write wait.
REQ-005 The block SHALL have the port: con_ff  in  1  branch condition flip-flop value.
REQ-006 The block SHALL have the port: stop  in  1  pause request; it is honoured only in T0.
REQ-007 The block SHALL have the ports: Gra, Grb, Grc, Rin, Rout, BAout  out  1 each  register select/encode controls.
REQ-008 The block SHALL have the ports: PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin, Yin, Zin, Zlowout, Cout, CONin, Read, Write  out  1 each  datapath strobes.
REQ-009 The block SHALL have the port: alu_op  out  5  ALU operation code.
REQ-010 The block SHALL have the ports: run  out  1; step  out  4 (current T-state index, 0-7; 8 means HALT).

Function
REQ-011 The block SHALL hold the state in a register updated on the clock edge; all outputs SHALL be a combinational decode of the state and IR.
REQ-012 The states SHALL be T0..T7 and HALT; any strobe not listed for a state SHALL be 0; alu_op SHALL be 00011 (ADD) unless stated otherwise.
REQ-013 T0 SHALL assert PCout, MARin, IncPC and Zin, then go to T1.
- Exception: when stop=1 in T0, all strobes SHALL be 0 and the state SHALL stay T0.
REQ-014 T1 SHALL assert Zlowout, PCin, Read and MDRin, and SHALL stay in T1 until mem_ready=1, then go to T2.
REQ-015 T2 SHALL assert MDRout and IRin, then go to T3.
REQ-016 From T3, the opcode SHALL be decoded from IR, which is stable from T3 onward.
REQ-017 R-type opcodes (00011 add, 00100 sub, 00101 and, 00110 or) SHALL use this sequence:
- T3: Grb, Rout, Yin.
- T4: Grc, Rout, Zin, with alu_op = opcode.
- T5: Zlowout, Gra, Rin.
- Then T0.
REQ-018 ld (00000) SHALL use this sequence:
- T3: Grb, BAout, Yin.
- T4: Cout, Zin.
- T5: Zlowout, MARin.
- T6: Read, MDRin; hold in T6 until mem_ready.
- T7: MDRout, Gra, Rin.
- Then T0.
REQ-019 st (00010) SHALL use the same T3-T5 as ld, then:
- T6: Gra, Rout, MDRin.
- T7: Write; hold in T7 until mem_ready.
- Then T0.
REQ-020 br (10010) SHALL use this sequence:
- T3: Gra, Rout, CONin.
- T4: PCout, Yin.
- T5: Cout, Zin.
- T6: Zlowout, and PCin only when con_ff=1.
- Then T0.
REQ-021 nop (11010) and every undefined opcode SHALL go from T3 to T0 with no strobes asserted in T3.
REQ-022 halt (11011) SHALL enter HALT from T3.
- HALT SHALL drive all strobes 0 and run=0.
- HALT SHALL be left only by reset.
REQ-023 mem_ready outside T1, T6 (ld) and T7 (st) SHALL be ignored; stop outside T0 SHALL be ignored.
REQ-024 Exactly one of Rin or Rout/BAout SHALL be asserted with any Gr* in a cycle, and at most one of Gra/Grb/Grc SHALL be asserted per cycle.

Reset
REQ-025 When reset=1 at a clock edge, the state SHALL become T0 from any state, including mid-wait and HALT.
REQ-026 While reset=1, all strobes SHALL be 0, alu_op SHALL be 00000, run SHALL be 0 and step SHALL be 0.
REQ-027 After reset is released, run SHALL be 1 and T0 outputs SHALL appear in the first cycle.

Verification
REQ-028 The bench SHALL cover: reset, then IR=add (0x1A0B8000 for Ra=4, Rb=1, Rc=7), mem_ready=1 in T1 -> steps 0,1,2,3,4,5,0; alu_op=00011 in T4; Gra&Rin in T5.
REQ-029 The bench SHALL cover: ld with mem_ready low for 3 cycles in T6 -> Read and MDRin held for 4 cycles; T7 asserts Gra, Rin, MDRout; total 11 cycles.
REQ-030 The bench SHALL cover: br with con_ff=0, then with con_ff=1 -> PCin in T6 is 0, then 1; both return to T0.
REQ-031 The bench SHALL cover: halt opcode 11011 -> step=8 and run=0 for 20 cycles; then reset=1 for one edge -> step=0, run=1.
REQ-032 The bench SHALL cover: stop=1 in T0 for 5 cycles -> no strobes and step stays 0; stop=0 -> PCout, MARin, IncPC, Zin asserted.
REQ-033 The bench SHALL cover: reset asserted during the st T7 wait -> next cycle step=0 and Write=0.
